// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-stage constants and the ifetch FSM state encoding.
package cpu_pkg;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int ROM_AW = 14;
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;
endpackage

// File: rtl/ifetch_unit_next_pc_mux.sv
// next_pc_mux: branch-taken decode and prioritised next-PC selection.
module next_pc_mux (
    input  logic [31:0] pc,
    input  logic [31:0] pc_plus_4,
    input  logic [31:0] instruction,
    input  logic [31:0] addr_result,
    input  logic [31:0] read_data_1,
    input  logic        hold,
    input  logic        branch,
    input  logic        nbranch,
    input  logic        jmp,
    input  logic        jal,
    input  logic        jr,
    input  logic        zero,
    output logic [31:0] next_pc
);
    logic taken;
    logic unused_bits;
    assign unused_bits = ^{read_data_1[1:0], addr_result[31:30], instruction[31:26]};
    assign taken = (branch & zero) | (nbranch & ~zero);
    // addr_result is a word index, so it is shifted back into a byte address
    assign next_pc = hold        ? pc :
                     jr          ? {read_data_1[31:2], 2'b00} :
                     (jmp | jal) ? {pc_plus_4[31:28], instruction[25:0], 2'b00} :
                     taken       ? {addr_result[29:0], 2'b00} :
                                   pc_plus_4;
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: PC, BOOT/RUN/HOLD FSM and Jal link register feeding a 1-cycle ROM.
// Defining IFETCH_RETIRE_CNT_EN adds the retire_cnt output.
module ifetch_unit
    import cpu_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        Branch,
    input  logic        nBranch,
    input  logic        Jmp,
    input  logic        Jal,
    input  logic        Jr,
    input  logic        Zero,
    input  logic [31:0] Addr_Result,
    input  logic [31:0] Read_data_1,
    output logic [13:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic [31:0] Instruction,
    output logic [31:0] PC_plus_4,
    output logic [31:0] link_addr,
    output logic        instr_valid
`ifdef IFETCH_RETIRE_CNT_EN
    ,
    output logic [31:0] retire_cnt
`endif
);
    state_t state, state_n;
    logic [31:0] pc, next_pc;
    logic run_go;
    assign PC_plus_4 = pc + 32'd4;
    assign Instruction = rom_data;
    // The ROM is addressed with next_pc so its registered output lines up with pc
    assign rom_addr = reset_n ? next_pc[ROM_AW+1:2] : '0;
    next_pc_mux u_mux (
        .pc          (pc),
        .pc_plus_4   (PC_plus_4),
        .instruction (rom_data),
        .addr_result (Addr_Result),
        .read_data_1 (Read_data_1),
        .hold        (stall | (state == BOOT)),
        .branch      (Branch),
        .nbranch     (nBranch),
        .jmp         (Jmp),
        .jal         (Jal),
        .jr          (Jr),
        .zero        (Zero),
        .next_pc     (next_pc)
    );
    always_comb begin
        state_n     = (state == BOOT) ? RUN : (stall ? HOLD : RUN);
        instr_valid = (state == RUN);
        run_go      = (state == RUN) & ~stall;
    end
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= BOOT;
            pc        <= RESET_PC;
            link_addr <= '0;
        end else begin
            state <= state_n;
            pc    <= next_pc;
            if (run_go && Jal) link_addr <= PC_plus_4;
        end
    end
`ifdef IFETCH_RETIRE_CNT_EN
    always_ff @(posedge clock) begin
        if (!reset_n) retire_cnt <= '0;
        else if (run_go) retire_cnt <= retire_cnt + 32'd1;
    end
`endif
endmodule
